// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core types: memory op encoding, LSU FSM states, byte-enable masks.
// Also used by the core decoder.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        OP_FETCH = 4'd0,
        OP_LW    = 4'd1,
        OP_LB    = 4'd2,
        OP_LBU   = 4'd3,
        OP_LH    = 4'd4,
        OP_LHU   = 4'd5,
        OP_LWL   = 4'd6,
        OP_LWR   = 4'd7,
        OP_SW    = 4'd8,
        OP_SH    = 4'd9,
        OP_SB    = 4'd10
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // LWL/LWR and byte ops are legal at any offset.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] k);
        case (op)
            OP_FETCH, OP_LW, OP_SW: return k != 2'b00;
            OP_LH, OP_LHU, OP_SH:   return k[0];
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_bus_lsu_if.sv
// Core request/response channel plus Avalon-MM master signals of the LSU.
interface mips_cpu_bus_lsu_if
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    mem_op_t               req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [31:0]           req_rt_old;
    logic                  rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_error;
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [3:0]            byteenable;
    logic [31:0]           writedata;
    logic                  waitrequest;
    logic [31:0]           readdata;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_rt_old, waitrequest, readdata,
        output req_ready, rsp_valid, rsp_data, rsp_error,
               address, read, write, byteenable, writedata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_rt_old, waitrequest, readdata,
        input  req_ready, rsp_valid, rsp_data, rsp_error,
               address, read, write, byteenable, writedata
    );

endinterface

// File: rtl/mips_cpu_bus_lane.sv
// Combinational byte-lane logic: store byteenable/writedata replication and
// load extract/extend plus the LWL/LWR merge with the old rt value.
module mips_cpu_bus_lane
    import mips_cpu_pkg::*;
(
    input  mem_op_t     i_op,
    input  logic [1:0]  i_k,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt_old,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_shl;
    logic [4:0]  w_shr;

    always_comb begin
        w_byte  = 8'(i_rdata >> {i_k, 3'b000});
        w_half  = i_k[1] ? i_rdata[31:16] : i_rdata[15:0];
        // 8*(3-k) for LWL and 8*k for LWR
        w_shl   = {~i_k, 3'b000};
        w_shr   = {i_k, 3'b000};
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_op)
            OP_SB: begin
                o_be    = BE_BYTE << i_k;
                o_wdata = {4{i_wdata[7:0]}};
            end
            OP_SH: begin
                o_be    = BE_HALF << i_k;
                o_wdata = {2{i_wdata[15:0]}};
            end
            OP_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_rdata = {24'h0, w_byte};
            OP_LH:  o_rdata = {{16{w_half[15]}}, w_half};
            OP_LHU: o_rdata = {16'h0, w_half};
            OP_LWL: o_rdata = (i_rdata << w_shl) | (i_rt_old & ~(32'hFFFF_FFFF << w_shl));
            OP_LWR: o_rdata = (i_rdata >> w_shr) | (i_rt_old & ~(32'hFFFF_FFFF >> w_shr));
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus_lsu.sv
// Avalon-MM load/store front-end for the multicycle MIPS core: one request at a
// time, waitrequest stalls with optional timeout, misalignment errors.
module mips_cpu_bus_lsu
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 64,
    parameter int CNT_WIDTH  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic               clk,
    input  logic               reset,
    mips_cpu_bus_lsu_if.master bus
);
    lsu_state_t            r_state, w_next;
    mem_op_t               r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rt_old;
    logic [31:0]           r_rdata;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_err;
    logic                  w_timeout;
    logic                  w_store;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;

    assign w_store = is_store(r_op);

    mips_cpu_bus_lane u_lane (
        .i_op     (r_op),
        .i_k      (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (r_rdata),
        .i_rt_old (r_rt_old),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_FETCH;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rt_old <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_op     <= bus.req_op;
                    r_addr   <= bus.req_addr;
                    r_wdata  <= bus.req_wdata;
                    r_rt_old <= bus.req_rt_old;
                    r_err    <= is_misaligned(bus.req_op, bus.req_addr[1:0]);
                    r_cnt    <= '0;
                end
                S_BUS: begin
                    if (bus.waitrequest) r_cnt <= r_cnt + 1'b1;
                    if (w_timeout)       r_err <= 1'b1;
                end
                S_DATA:  r_rdata <= bus.readdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: if (bus.req_valid)
                w_next = is_misaligned(bus.req_op, bus.req_addr[1:0]) ? S_RESP : S_BUS;
            S_BUS: begin
                if (!bus.waitrequest) begin
                    w_next = w_store ? S_RESP : S_DATA;
                end else if (MAX_WAIT != 0 && r_cnt == CNT_WIDTH'(MAX_WAIT - 1)) begin
                    // this stalled cycle is number MAX_WAIT: abandon the transfer
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_DATA:  w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase

        bus.req_ready  = (r_state == S_IDLE);
        bus.rsp_valid  = (r_state == S_RESP);
        bus.rsp_error  = (r_state == S_RESP) && r_err;
        bus.rsp_data   = (r_state == S_RESP && !r_err && !w_store) ? w_rdata : 32'h0;
        bus.read       = (r_state == S_BUS) && !w_store;
        bus.write      = (r_state == S_BUS) && w_store;
        bus.address    = (r_state == S_BUS) ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
        bus.byteenable = (r_state == S_BUS) ? w_be : 4'h0;
        bus.writedata  = bus.write ? w_wdata : 32'h0;
    end

endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// Directed bench for mips_cpu_bus_lsu: Avalon slave model with programmable
// stalls, expected responses queued at issue and compared on rsp_valid.
module tb_mips_cpu_bus_lsu;
    import mips_cpu_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          stall_target = 0;
    int          wait_seen = 0;
    logic [31:0] mem [0:4095];
    exp_t        exp_q [$];

    mips_cpu_bus_lsu_if #(.ADDR_WIDTH(32)) bus ();

    mips_cpu_bus_lsu #(.ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.waitrequest = (bus.read | bus.write) && (wait_seen < stall_target);

    always @(posedge clk) begin
        wait_seen    <= bus.waitrequest ? wait_seen + 1 : 0;
        bus.readdata <= (bus.read && !bus.waitrequest) ? mem[bus.address[13:2]] : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, trace the bus until rsp_valid, then score the response.
    task automatic run(input string tag, input mem_op_t op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rt,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                       output int rd_n, output int wr_n, output logic [31:0] a0,
                       output logic [3:0] be0, output logic [31:0] wd0);
        exp_t e;
        int   n;
        int   unstable;
        bit   done;
        rd_n = 0; wr_n = 0; a0 = 0; be0 = 0; wd0 = 0; unstable = 0;
        @(posedge clk); #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_rt_old = rt;
        exp_q.push_back('{exp_data, exp_err, exp_lat});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.read || bus.write) begin
                if (rd_n + wr_n == 0) begin
                    a0 = bus.address; be0 = bus.byteenable; wd0 = bus.writedata;
                end else if (bus.address !== a0 || bus.byteenable !== be0 || bus.writedata !== wd0) begin
                    unstable++;
                end
                if (bus.read && bus.write) unstable++;
                if (bus.read) rd_n++;
                if (bus.write) wr_n++;
            end
            if (bus.rsp_valid) done = 1;
        end
        chk({tag, "_rsp_seen"}, 32'(done), 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_data"}, bus.rsp_data, e.data);
        chk({tag, "_err"}, 32'(bus.rsp_error), 32'(e.err));
        chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        chk({tag, "_stable"}, 32'(unstable), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int          rd_n, wr_n;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;

        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_FETCH;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rt_old = 32'h0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_read", 32'(bus.read), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_address", bus.address, 32'h0);
        chk("rst_be", 32'(bus.byteenable), 32'd0);

        mem[32'h1000 >> 2] = 32'hDEAD_BEEF;
        run("lw", OP_LW, 32'h1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        chk("lw_rd_cycles", 32'(rd_n), 32'd1);
        chk("lw_addr", a0, 32'h1000);
        chk("lw_be", 32'(be0), 32'hF);

        mem[32'h1000 >> 2] = 32'h80FF_7F01;
        run("lb", OP_LB, 32'h1003, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        chk("lb_addr", a0, 32'h1000);
        run("lbu", OP_LBU, 32'h1003, 32'h0, 32'h0, 32'h0000_0080, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        run("lb0", OP_LB, 32'h1000, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        run("lh", OP_LH, 32'h1002, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        run("lhu", OP_LHU, 32'h1000, 32'h0, 32'h0, 32'h0000_7F01, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);

        stall_target = 3;
        run("sh", OP_SH, 32'h2002, 32'h0000_ABCD, 32'h0, 32'h0, 1'b0, 5, rd_n, wr_n, a0, be0, wd0);
        chk("sh_wr_cycles", 32'(wr_n), 32'd4);
        chk("sh_rd_cycles", 32'(rd_n), 32'd0);
        chk("sh_addr", a0, 32'h2000);
        chk("sh_be", 32'(be0), 32'b1100);
        chk("sh_wd", wd0, 32'hABCD_ABCD);
        stall_target = 0;

        run("sb", OP_SB, 32'h2001, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 2, rd_n, wr_n, a0, be0, wd0);
        chk("sb_wr_cycles", 32'(wr_n), 32'd1);
        chk("sb_be", 32'(be0), 32'b0010);
        chk("sb_wd", wd0, 32'h7878_7878);
        run("sw", OP_SW, 32'h2004, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 2, rd_n, wr_n, a0, be0, wd0);
        chk("sw_be", 32'(be0), 32'hF);
        chk("sw_wd", wd0, 32'hCAFE_F00D);

        mem[32'h3000 >> 2] = 32'h4433_2211;
        run("lwl", OP_LWL, 32'h3001, 32'h0, 32'hAAAA_AAAA, 32'h2211_AAAA, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        chk("lwl_addr", a0, 32'h3000);
        run("lwr", OP_LWR, 32'h3001, 32'h0, 32'hAAAA_AAAA, 32'hAA44_3322, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        run("lwl3", OP_LWL, 32'h3003, 32'h0, 32'hAAAA_AAAA, 32'h4433_2211, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);

        run("lh_mis", OP_LH, 32'h0001, 32'h0, 32'h0, 32'h0, 1'b1, 1, rd_n, wr_n, a0, be0, wd0);
        chk("lh_mis_rd_cycles", 32'(rd_n), 32'd0);
        run("sw_mis", OP_SW, 32'h0002, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1, rd_n, wr_n, a0, be0, wd0);
        chk("sw_mis_wr_cycles", 32'(wr_n), 32'd0);

        stall_target = 1000;
        run("tmo", OP_LW, 32'h1000, 32'h0, 32'h0, 32'h0, 1'b1, 5, rd_n, wr_n, a0, be0, wd0);
        chk("tmo_rd_cycles", 32'(rd_n), 32'd4);

        // reset while stalled in the bus phase
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'h1000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_read_before", 32'(bus.read), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        stall_target = 0;
        @(negedge clk);
        chk("rstmid_read", 32'(bus.read), 32'd0);
        chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
        run("post_rst_lw", OP_LW, 32'h1000, 32'h0, 32'h0, 32'h80FF_7F01, 1'b0, 3, rd_n, wr_n, a0, be0, wd0);
        chk("post_rst_rd_cycles", 32'(rd_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
